// File: rtl/wallace_pkg.sv
// Shared sizing helpers for the Wallace-tree pipelined multiplier: CSA level
// counting, level-to-stage split and parameter legality.
package wallace_pkg;

  // Rows left after applying lvls levels of 3:2 reduction to a tree of rows
  function automatic int rows_after(input int rows, input int lvls);
    int n;
    n = rows;
    for (int i = 0; i < lvls; i++) begin
      if (n > 2) n = 2 * (n / 3) + n % 3;
    end
    return n;
  endfunction

  function automatic int csa_levels(input int rows);
    int n;
    int c;
    n = rows;
    c = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      c++;
    end
    return c;
  endfunction

  function automatic int lvls_per_stage(input int levels, input int stages);
    return (levels + stages - 1) / stages;
  endfunction

  // Levels owned by stage idx (0-based); trailing stages may own none
  function automatic int stage_levels(input int levels, input int stages, input int idx);
    int lps;
    int rem;
    lps = lvls_per_stage(levels, stages);
    rem = levels - idx * lps;
    if (rem <= 0) return 0;
    return (rem < lps) ? rem : lps;
  endfunction

  function automatic bit params_ok(input int width, input int stages);
    return (width >= 4) && (width <= 64) && (stages >= 1) && (stages <= 6);
  endfunction

endpackage

// File: rtl/wallace_stage.sv
// One pipeline segment: this stage's share of CSA levels, then a register row
// and valid bit. The last stage also does the final carry-propagate add into row 0.
module wallace_stage import wallace_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int IDX    = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en_i,
  input  logic                              vld_i,
  input  logic [WIDTH:0][2*WIDTH-1:0]       rows_i,
  output logic                              vld_o,
  output logic [WIDTH:0][2*WIDTH-1:0]       rows_o
);
  localparam int NR     = WIDTH + 1;
  localparam int PW     = 2 * WIDTH;
  localparam int LEVELS = csa_levels(NR);
  localparam int FIRST  = IDX * lvls_per_stage(LEVELS, STAGES);
  localparam int NL     = stage_levels(LEVELS, STAGES, IDX);
  localparam bit LAST   = (IDX == STAGES - 1);

  logic [NR-1:0][PW-1:0] lvl [NL+1];
  logic [NR-1:0][PW-1:0] rows_d, rows_q;
  logic                  vld_q;

  assign lvl[0] = rows_i;

  // Each level packs sums first, then carries, then uncompressed leftovers;
  // rows beyond the live count are zero and stay zero.
  for (genvar l = 0; l < NL; l++) begin : g_lvl
    localparam int N = rows_after(NR, FIRST + l);
    localparam int G = N / 3;
    for (genvar k = 0; k < NR; k++) begin : g_row
      if (k < G) begin : g_sum
        assign lvl[l+1][k] = lvl[l][3*k] ^ lvl[l][3*k+1] ^ lvl[l][3*k+2];
      end else if (k < 2 * G) begin : g_cry
        assign lvl[l+1][k] = ((lvl[l][3*(k-G)]   & lvl[l][3*(k-G)+1]) |
                              (lvl[l][3*(k-G)]   & lvl[l][3*(k-G)+2]) |
                              (lvl[l][3*(k-G)+1] & lvl[l][3*(k-G)+2])) << 1;
      end else if (k < N - G) begin : g_pass
        assign lvl[l+1][k] = lvl[l][k+G];
      end else if (k < N) begin : g_zero
        assign lvl[l+1][k] = '0;
      end else begin : g_idle
        assign lvl[l+1][k] = lvl[l][k];
      end
    end
  end

  always_comb begin
    rows_d = lvl[NL];
    if (LAST) rows_d[0] = lvl[NL][0] + lvl[NL][1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      rows_q <= '0;
    end else if (en_i) begin
      vld_q  <= vld_i;
      rows_q <= rows_d;
    end
  end

  assign vld_o  = vld_q;
  assign rows_o = rows_q;

endmodule

// File: rtl/wallace_pipe_mult.sv
// Pipelined Wallace-tree multiplier, signed (Baugh-Wooley) or unsigned per op.
// Optional WALLACE_DONE_COUNT_EN builds a 32-bit completed-result counter.
module wallace_pipe_mult import wallace_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic [31:0]          done_count
);
  localparam int NR = WIDTH + 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [PW-1:0] CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("wallace_pipe_mult: WIDTH must be 4..64 and STAGES 1..6");
  end

  logic                  en;
  logic [NR-1:0][PW-1:0] pp;
  logic [STAGES:0]       vld_pipe;
  logic [NR-1:0][PW-1:0] rows_pipe [STAGES+1];
  logic                  unused_rows;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Signed mode inverts the cross terms touching exactly one sign bit and adds
  // the constant 2^W + 2^(2W-1) as the extra row.
  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp[i][i+j] = (a[j] & b[i]) ^ (signed_mode & ((i == WIDTH - 1) ^ (j == WIDTH - 1)));
      end
    end
    pp[WIDTH] = signed_mode ? CORR : '0;
  end

  assign vld_pipe[0]  = in_valid && in_ready;
  assign rows_pipe[0] = pp;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    wallace_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (s)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en),
      .vld_i  (vld_pipe[s]),
      .rows_i (rows_pipe[s]),
      .vld_o  (vld_pipe[s+1]),
      .rows_o (rows_pipe[s+1])
    );
  end

  assign out_valid   = vld_pipe[STAGES];
  assign p           = rows_pipe[STAGES][0];
  assign unused_rows = ^rows_pipe[STAGES][NR-1:1];

`ifdef WALLACE_DONE_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  assign cnt_d = cnt_q + 32'd1;

  always_ff @(posedge clk) begin
    if (rst)                         cnt_q <= '0;
    else if (out_valid && out_ready) cnt_q <= cnt_d;
  end

  assign done_count = cnt_q;
`else
  assign done_count = '0;
`endif

endmodule

// File: tb/tb_wallace_pipe_mult.sv
// Directed bench for wallace_pipe_mult (WIDTH=32, STAGES=3) with hand-computed products.
module tb_wallace_pipe_mult;
  localparam int WIDTH  = 32;
  localparam int STAGES = 3;
`ifdef WALLACE_DONE_COUNT_EN
  localparam bit DC_ON = 1'b1;
`else
  localparam bit DC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] p;
  logic [31:0] done_count;

  int n_chk = 0;
  int n_err = 0;

  wallace_pipe_mult #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .p           (p),
    .done_count  (done_count)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] SA [10] = '{32'h3, 32'hFFFFFFFF, 32'h00010000, 32'h80000000, 32'h7FFFFFFF,
                                      32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF0, 32'h12345678, 32'h0};
  localparam logic [31:0] SB [10] = '{32'h5, 32'h7, 32'h00010000, 32'h2, 32'h7FFFFFFF,
                                      32'h80000000, 32'h2, 32'hFFFFFFF0, 32'h10, 32'h80000000};
  localparam logic        SS [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [63:0] SP [10] = '{64'hF, 64'hFFFFFFFFFFFFFFF9, 64'h100000000, 64'h100000000,
                                      64'h3FFFFFFF00000001, 64'hC000000080000000, 64'h1FFFFFFFE,
                                      64'h100, 64'h123456780, 64'h0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with an empty pipe; result consumed on the following edge
  task automatic run_one(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic sm, input logic [63:0] ep);
    int lat;
    in_valid = 1'b1; a = av; b = bv; signed_mode = sm; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'hCAFEF00D;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(STAGES));
    chk(tag, p, ep);
    @(posedge clk); #1;
  endtask

  initial begin
    int si, ri;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_p", p, 64'd0);
    chk("rst_done_count", 64'(done_count), 64'd0);
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Garbage operands with in_valid low must never produce a result
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; signed_mode = i[0];
      @(posedge clk); #1;
      chk("idle_out_valid", 64'(out_valid), 64'd0);
    end

    run_one("s_ones",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001);
    run_one("u_ones",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001);
    run_one("s_minsq",  32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000);
    run_one("s_min_1",  32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000);
    run_one("s_m2_3",   32'hFFFFFFFE, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFFA);
    chk("done_count_5", 64'(done_count), DC_ON ? 64'd5 : 64'd0);

    // Back-to-back stream with the consumer stalled for cycles 4..8
    si = 0; ri = 0;
    for (int cyc = 0; cyc < 60 && ri < 10; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 8);
      in_valid  = (si < 10);
      if (si < 10) begin
        a = SA[si]; b = SB[si]; signed_mode = SS[si];
      end else begin
        a = 32'hA5A5A5A5; b = 32'h5A5A5A5A; signed_mode = 1'b1;
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        chk("stream_p", p, SP[ri]);
        ri++;
      end else if (out_valid) begin
        chk("stall_p", p, SP[ri]);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
      if (in_valid && in_ready) si++;
      @(posedge clk); #1;
    end
    chk("stream_count", 64'(ri), 64'd10);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_count_15", 64'(done_count), DC_ON ? 64'd15 : 64'd0);

    // Two products in flight, then a one-cycle reset
    in_valid = 1'b1; a = 32'd5; b = 32'd6; signed_mode = 1'b0;
    @(posedge clk); #1;
    a = 32'd7; b = 32'd8;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_p", p, 64'd0);
    chk("rst_mid_done_count", 64'(done_count), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_no_ghost", 64'(out_valid), 64'd0);
    end

    run_one("post_rst", 32'h0000FFFF, 32'h0000FFFF, 1'b0, 64'h00000000FFFE0001);
    chk("done_count_1", 64'(done_count), DC_ON ? 64'd1 : 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/wallace_pipe_mult.md
WALLACE_PIPE_MULT -- requirements
Module: wallace_pipe_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal range 4..64).
REQ-002 SHALL have parameter STAGES, default 3, pipeline register count from operand capture to result (legal range 1..6).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  multiplicand.
REQ-008 SHALL have port b  input  WIDTH  multiplier.
REQ-009 SHALL have port signed_mode  input  1  1 = both operands two's complement, 0 = both unsigned; sampled with a/b.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port p  output  2*WIDTH  product.
REQ-013 SHALL have port done_count  output  32  completed-result counter (see Configuration).

Function
REQ-014 p SHALL equal the exact 2*WIDTH-bit product of a and b interpreted per signed_mode.
REQ-015 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-016 Global advance enable SHALL be en = !out_valid || out_ready; in_ready SHALL equal en.
REQ-017 When en is high every stage register SHALL load from its predecessor, with stage 1 loading the input and its valid bit set to (in_valid && in_ready); when en is low all stages SHALL hold.
REQ-018 With out_ready held high, a transfer in cycle N SHALL produce out_valid and p in cycle N+STAGES.
REQ-019 Throughput SHALL be one product per cycle with no stall; bubbles SHALL propagate and SHALL NOT be collapsed.
REQ-020 While out_valid && !out_ready, p SHALL remain stable and no accepted operand SHALL be lost, duplicated or reordered.
REQ-021 Partial products SHALL be generated as WIDTH rows plus one constant correction row (Baugh-Wooley in signed mode, zero in unsigned mode), reduced by levels of 3:2 carry-save adders, with a final carry-propagate add in the last stage.
REQ-022 CSA levels SHALL be split across stages as ceil(levels/STAGES) levels per stage, with the carry-propagate add in stage STAGES.
REQ-023 in_valid low in every cycle SHALL leave out_valid low; a and b SHALL be ignored when in_valid is low.

Reset
REQ-024 While rst is high at a clock edge, all stage valid bits, out_valid and done_count SHALL clear to 0 and p SHALL clear to 0.
REQ-025 rst asserted mid-operation SHALL discard all in-flight products; no pre-reset product SHALL appear at the output.
REQ-026 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-027 Macro WALLACE_DONE_COUNT_EN defined: done_count SHALL increment by 1 per output transfer and wrap from 0xFFFFFFFF to 0.
REQ-028 Macro WALLACE_DONE_COUNT_EN undefined: done_count SHALL be tied to constant 0 and no counter flop SHALL be built.

Structure
REQ-029 Package wallace_pkg SHALL hold the CSA level-count function (from row count), the levels-per-stage function, and parameter legality checks.
REQ-030 One sub-module wallace_stage SHALL implement one pipeline segment (its CSA levels plus its register row and valid bit), instantiated STAGES times; CSA cells SHALL be the team's existing CSA.

Verification
REQ-031 WIDTH=32, STAGES=3, signed, a=0xFFFFFFFF, b=0xFFFFFFFF -> p=0x0000000000000001, out_valid 3 cycles after transfer.
REQ-032 Unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF -> p=0xFFFFFFFE00000001.
REQ-033 Signed, a=0x80000000, b=0x80000000 -> p=0x4000000000000000; signed a=0x80000000, b=0x00000001 -> p=0xFFFFFFFF80000000.
REQ-034 Stream 10 random pairs back-to-back, out_ready low for cycles 4-8 -> in_ready low while the pipe is full, all 10 results correct and in order, p stable during stall.
REQ-035 2 products in flight, rst high for 1 cycle -> out_valid 0 next cycle, neither product emitted, in_ready 1 after rst deasserts.
REQ-036 With WALLACE_DONE_COUNT_EN, 5 output transfers -> done_count=5; without the macro -> done_count=0 throughout.
